// File: rtl/systolic_feeder.sv
// Input staging for a systolic row: accepts activation vectors, skews lane r by r cycles,
// and emits the clock-enable, weight address and control word that travel with lane 0.
module systolic_feeder #(
  parameter int WIDTH          = 8,
  parameter int ROWS           = 4,
  parameter int MEM_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*WIDTH-1:0]     in_data,
  input  logic                      in_last,
  output logic                      ce_out,
  output logic [ROWS*WIDTH-1:0]     x_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_out,
  output logic [31:0]               ctrl_out,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam int DCW = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((ROWS > 1) ? ROWS - 2 : 0);

  state_t         state;
  state_t         state_next;
  logic [DCW-1:0] drain_cnt;
  logic [15:0]    vec_cnt;
  logic           accept;
  logic           shift;
  logic           tile_end;
  logic [31:0]    ctrl_next;

  assign in_ready = (state != DRAIN);
  assign accept   = in_valid & in_ready;
  assign shift    = (state != IDLE) | accept;

  // A single-row array needs no drain: the last vector is complete one cycle after accept.
  always_comb begin
    state_next = state;
    tile_end   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_last) begin
            state_next = STREAM;
          end else if (ROWS == 1) begin
            tile_end = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      STREAM: begin
        if (accept && in_last) begin
          if (ROWS == 1) begin
            state_next = IDLE;
            tile_end   = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = IDLE;
          tile_end   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ctrl_next        = '0;
    ctrl_next[0]     = accept;
    ctrl_next[1]     = accept & (state == IDLE);
    ctrl_next[2]     = accept & in_last;
    ctrl_next[3]     = (state_next == DRAIN);
    ctrl_next[31:16] = accept ? vec_cnt : ctrl_out[31:16];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt <= '0;
    end else if (state_next == IDLE) begin
      vec_cnt <= '0;
    end else if (accept && (vec_cnt != '1)) begin
      vec_cnt <= vec_cnt + 16'd1;
    end
  end

  // Address and index hold through bubbles and drain so they always name the last real vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_out       <= 1'b0;
      done         <= 1'b0;
      mem_addr_out <= '0;
      ctrl_out     <= '0;
    end else begin
      ce_out   <= accept | (state_next != IDLE);
      done     <= tile_end;
      ctrl_out <= ctrl_next;
      if (accept) begin
        mem_addr_out <= MEM_ADDR_WIDTH'(vec_cnt);
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [WIDTH-1:0] chain [r+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k <= unsigned'(r); k++) begin
          chain[k] <= '0;
        end
      end else if (shift) begin
        chain[0] <= accept ? in_data[r*WIDTH +: WIDTH] : '0;
        for (int unsigned k = 1; k <= unsigned'(r); k++) begin
          chain[k] <= chain[k-1];
        end
      end
    end

    assign x_out[r*WIDTH +: WIDTH] = chain[r];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a directed vector table, hand sequences for tile corners,
// and random traffic checked against a cycle-timeline model of the feeder's behaviour.
module tb_systolic_feeder;

  localparam int WIDTH = 8;
  localparam int ROWS  = 4;
  localparam int MAW   = 4;
  localparam int DW    = ROWS * WIDTH;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           in_last;
  logic           ce_out;
  logic [DW-1:0]  x_out;
  logic [MAW-1:0] mem_addr_out;
  logic [31:0]    ctrl_out;
  logic           done;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_feeder #(
    .WIDTH(WIDTH),
    .ROWS(ROWS),
    .MEM_ADDR_WIDTH(MAW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .ce_out(ce_out),
    .x_out(x_out),
    .mem_addr_out(mem_addr_out),
    .ctrl_out(ctrl_out),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed records: inputs for one cycle and the outputs expected after that cycle's edge.
  typedef struct {
    logic           v;
    logic           l;
    logic [DW-1:0]  d;
    logic [DW-1:0]  x;
    logic           ce;
    logic [MAW-1:0] mem;
    logic [31:0]    ctrl;
    logic           dn;
    logic           rdy;
  } vec_t;

  vec_t tbl [14];

  // Timeline model: the tile ends ROWS cycles after its last accept; lanes read the shift history.
  logic [DW-1:0]  hist [$];
  bit             m_in_tile;
  bit             m_last_seen;
  int             m_cyc;
  int             m_drain_end;
  int unsigned    m_count;
  logic [15:0]    m_idx;
  logic [MAW-1:0] m_mem;
  bit             last_acc;

  task automatic model_reset();
    hist.delete();
    m_in_tile   = 0;
    m_last_seen = 0;
    m_cyc       = 0;
    m_drain_end = 0;
    m_count     = 0;
    m_idx       = '0;
    m_mem       = '0;
  endtask

  task automatic mstep(input logic v, input logic [DW-1:0] d, input logic l);
    bit            draining;
    bit            acc;
    bit            idle;
    bit            first;
    bit            exp_done;
    bit            exp_drain;
    bit            exp_ce;
    int            nxt;
    logic [DW-1:0] exp_x;
    logic [DW-1:0] e;
    logic [31:0]   exp_ctrl;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    draining = m_last_seen && (m_cyc < m_drain_end);
    #1;
    chk("ready", 32'(in_ready), 32'(!draining));
    acc   = v && !draining;
    idle  = !m_in_tile;
    first = acc && idle;
    if (!idle || acc) begin
      hist.push_back(acc ? d : '0);
      if (hist.size() > ROWS) void'(hist.pop_front());
    end
    if (acc) begin
      m_idx = 16'(m_count);
      m_mem = MAW'(m_count);
      if (m_count < 32'hFFFF) m_count++;
      m_in_tile = 1;
      if (l) begin
        m_last_seen = 1;
        m_drain_end = m_cyc + ROWS;
      end
    end
    nxt      = m_cyc + 1;
    exp_done = m_in_tile && m_last_seen && (nxt >= m_drain_end);
    if (exp_done) begin
      m_in_tile   = 0;
      m_last_seen = 0;
      m_count     = 0;
    end
    exp_drain = m_last_seen && (nxt < m_drain_end);
    exp_ce    = acc || m_in_tile;
    exp_ctrl  = {m_idx, 12'b0, exp_drain, acc && l, first, acc};
    exp_x     = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (hist.size() > r) begin
        e = hist[hist.size() - 1 - r];
        exp_x[r*WIDTH +: WIDTH] = e[r*WIDTH +: WIDTH];
      end
    end
    m_cyc    = nxt;
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("x_out", x_out, exp_x);
    chk("ce_out", 32'(ce_out), 32'(exp_ce));
    chk("mem_addr", 32'(mem_addr_out), 32'(m_mem));
    chk("ctrl_out", ctrl_out, exp_ctrl);
    chk("done", 32'(done), 32'(exp_done));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk({tag, "_x"}, x_out, '0);
    chk({tag, "_ce"}, 32'(ce_out), 0);
    chk({tag, "_mem"}, 32'(mem_addr_out), 0);
    chk({tag, "_ctrl"}, ctrl_out, 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ready"}, 32'(in_ready), 1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk({tag, "_no_done"}, 32'(done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int lows;
    int guard;
    logic [DW-1:0] d2;

    tbl[0]  = '{1, 0, 32'h04030201, 32'h00000001, 1, 0, 32'h00000003, 0, 1};
    tbl[1]  = '{0, 0, 32'h00000000, 32'h00000200, 1, 0, 32'h00000000, 0, 1};
    tbl[2]  = '{0, 0, 32'h00000000, 32'h00030000, 1, 0, 32'h00000000, 0, 1};
    tbl[3]  = '{1, 0, 32'h08070605, 32'h04000005, 1, 1, 32'h00010001, 0, 1};
    tbl[4]  = '{1, 1, 32'h0C0B0A09, 32'h00000609, 1, 2, 32'h0002000D, 0, 0};
    tbl[5]  = '{1, 0, 32'h100F0E0D, 32'h00070A00, 1, 2, 32'h00020008, 0, 0};
    tbl[6]  = '{1, 0, 32'h100F0E0D, 32'h080B0000, 1, 2, 32'h00020008, 0, 0};
    tbl[7]  = '{1, 0, 32'h100F0E0D, 32'h0C000000, 0, 2, 32'h00020000, 1, 1};
    tbl[8]  = '{1, 0, 32'h100F0E0D, 32'h0000000D, 1, 0, 32'h00000003, 0, 1};
    tbl[9]  = '{1, 1, 32'hFCFDFEFF, 32'h00000EFF, 1, 1, 32'h0001000D, 0, 0};
    tbl[10] = '{0, 0, 32'h00000000, 32'h000FFE00, 1, 1, 32'h00010008, 0, 0};
    tbl[11] = '{0, 0, 32'h00000000, 32'h10FD0000, 1, 1, 32'h00010008, 0, 0};
    tbl[12] = '{0, 0, 32'h00000000, 32'hFC000000, 0, 1, 32'h00010000, 1, 1};
    tbl[13] = '{0, 0, 32'h00000000, 32'hFC000000, 0, 1, 32'h00010000, 0, 1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    model_reset();
    #12;
    chk("rst_x", x_out, '0);
    chk("rst_ce", 32'(ce_out), 0);
    chk("rst_mem", 32'(mem_addr_out), 0);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v;
      in_last  = tbl[i].l;
      in_data  = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_x", i), x_out, tbl[i].x);
      chk($sformatf("tbl%0d_ce", i), 32'(ce_out), 32'(tbl[i].ce));
      chk($sformatf("tbl%0d_mem", i), 32'(mem_addr_out), 32'(tbl[i].mem));
      chk($sformatf("tbl%0d_ctrl", i), ctrl_out, tbl[i].ctrl);
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
    end

    do_reset("idle_rst");

    // Single-vector tile with extreme signed values.
    mstep(1, 32'h00FF7F80, 1);
    chk("single_flags", 32'(ctrl_out[2:0]), 32'h7);
    chk("single_lane0", 32'(x_out[7:0]), 32'h80);
    lows = in_ready ? 0 : 1;
    repeat (4) begin
      mstep(0, '0, 0);
      if (!in_ready) lows++;
    end
    chk("single_ready_low_cycles", lows, 3);

    // Address wrap over 18 vectors.
    for (int i = 0; i < 18; i++) begin
      mstep(1, DW'($urandom), (i == 17));
      chk($sformatf("wrap_mem%0d", i), 32'(mem_addr_out), 32'(i % 16));
      chk($sformatf("wrap_idx%0d", i), 32'(ctrl_out[31:16]), i);
    end
    repeat (4) mstep(0, '0, 0);

    // Back-to-back tiles with in_valid held high across the boundary.
    for (int i = 0; i < 3; i++) mstep(1, DW'($urandom), (i == 2));
    d2    = DW'($urandom);
    guard = 0;
    while (!done && guard < 10) begin
      mstep(1, d2, 0);
      guard++;
    end
    chk("b2b_done_seen", 32'(done), 1);
    chk("b2b_drain_len", guard, 3);
    mstep(1, d2, 0);
    chk("b2b_accept_at_done", 32'(last_acc), 1);
    chk("b2b_first_flag", 32'(ctrl_out[1]), 1);
    mstep(1, DW'($urandom), 1);
    repeat (4) mstep(0, '0, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      mstep(($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 9) < 2));
    end
    repeat (4) mstep(0, '0, 0);

    // Asynchronous reset in the middle of a stream.
    mstep(1, DW'($urandom), 0);
    mstep(1, DW'($urandom), 0);
    do_reset("stream_rst");
    mstep(1, 32'h11223344, 1);
    repeat (4) mstep(0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Input staging block directly upstream of a row of systolic cells. Accepts one activation vector per cycle over a valid/ready handshake. Emits the vector diagonally skewed (lane r delayed r cycles) onto the x inputs of the array rows. Generates the per-cycle clock-enable, weight-ROM address and 32-bit control word that the cells pipeline onward.

Parameters:
WIDTH, 8, signed activation width per lane
ROWS, 4, number of array rows/lanes fed (>=1)
MEM_ADDR_WIDTH, 4, width of weight-ROM address driven to cells

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream vector valid
in_ready  out  1  feeder can accept a vector this cycle
in_data  in  ROWS*WIDTH  activation vector; lane r = bits [r*WIDTH +: WIDTH], signed
in_last  in  1  qualifies the accepted vector as last of tile
ce_out  out  1  clock enable to array
x_out  out  ROWS*WIDTH  skewed activations; lane r to row r x_in
mem_addr_out  out  MEM_ADDR_WIDTH  weight address for the vector entering lane 0
ctrl_out  out  32  control word to the array's ctrl_in
done  out  1  one-cycle pulse when the tile has fully drained

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low. On assertion, immediately: state=IDLE, all skew registers 0, x_out=0, ce_out=0, mem_addr_out=0, ctrl_out=0, done=0, vector counter=0. Reset mid-tile discards the tile; no done pulse.
- Accept = in_valid & in_ready. in_ready=1 in IDLE and STREAM, 0 in DRAIN. in_ready is combinational from state only, never from in_valid.
- FSM:
  - IDLE -> STREAM on accept with in_last=0.
  - IDLE -> DRAIN on accept with in_last=1 (single-vector tile).
  - STREAM -> DRAIN on accept with in_last=1.
  - DRAIN -> IDLE after ROWS-1 drain cycles. For ROWS=1, DRAIN lasts 0 cycles and returns to IDLE immediately.
- Skew pipeline: lane r is a shift chain of r+1 registers. It shifts every cycle while state != IDLE or accept=1.
  - Input to each chain is in_data lane r on accept, else 0. STREAM bubbles (in_valid=0) inject zero vectors.
  - x_out lane r = last register of chain r. A value accepted in cycle t appears on lane r at cycle t+1+r.
- ce_out: registered. High from the cycle after the first accept of a tile through the last DRAIN cycle inclusive, including bubble cycles. Low in IDLE.
- Vector counter: 16-bit, cleared on entry to IDLE. Increments per accept and saturates at 0xFFFF.
- mem_addr_out: registered. Equals counter mod 2^MEM_ADDR_WIDTH for the vector presented on lane 0 that cycle, so it wraps naturally, e.g. 15 -> 0 for width 4. It holds its value on bubble/drain cycles.
- ctrl_out: registered, aligned with lane 0.
  - bit0 = lane-0 data valid (real vector, not bubble/drain).
  - bit1 = first vector of tile.
  - bit2 = last vector of tile.
  - bit3 = draining.
  - bits[15:4] = 0.
  - bits[31:16] = vector index of the lane-0 vector.
- done: registered one-cycle pulse in the cycle state returns to IDLE. That is the same cycle the final lane ROWS-1 value is on x_out.
- Back-to-back tiles: a new accept is allowed the cycle after done (IDLE). in_valid during DRAIN is held off by in_ready=0, and upstream must hold its data.
- Arithmetic: no arithmetic on data. Values pass through bit-exact, and sign is preserved.

Test Plan:
- Reset: drive rst_n=0 mid-STREAM, asynchronously, with no clock edge -> all outputs 0, in_ready=1, no done pulse.
- Single tile, ROWS=4: accept vectors V0={1,2,3,4}, V1={5,6,7,8}, V2 with in_last -> lane0 outputs 1,5,.. from t+1; lane3 outputs 4 at t+4. done pulses once, 3 cycles after the V2 accept+1, with lane3 showing V2[3].
- Bubble: hold in_valid=0 for 2 cycles between V0 and V1 -> zeros inserted on every lane, correctly skewed. ce_out stays 1. ctrl_out bit0=0 on the bubbles and mem_addr_out holds.
- Single-vector tile: accept {-128,127,-1,0} with in_last=1 from IDLE -> straight to DRAIN; in_ready=0 for 3 cycles. Signed values appear exactly; ctrl_out bits1 and 2 are both set on lane-0 cycle.
- Address wrap: stream 18 vectors with MEM_ADDR_WIDTH=4 -> mem_addr_out sequence 0..15,0,1. ctrl_out[31:16] runs 0..17.
- Back-to-back tiles: assert in_valid continuously across the tile boundary -> no accept while in DRAIN. The first vector of tile 2 is accepted the cycle done=1, and ctrl_out bit1 is set again.
